// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and the instruction feeder state type.
// Holds the NOP and EBREAK encodings and the opcode values that the
// multicycle core also uses, so the feeder and the core stay in step.
package riscv_pkg;

    localparam logic [31:0] NOP    = 32'h0000_0013; // addi x0, x0, 0
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/prog_mem.sv
// Program store: DEPTH x 32-bit register array.
// Ports:
//   clk    - write clock
//   we     - write enable, takes effect on the rising edge
//   waddr  - word write address
//   wdata  - instruction word to store
//   raddr  - word read address (asynchronous read)
//   rdata  - stored word at raddr, combinational
// No reset: the program survives feeder resets.
module prog_mem #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Zero-latency read: the core latches IR in the same cycle it presents PC.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_feeder.sv
// Instruction-supply front end for the memoryless multicycle RISC-V core.
// Ports:
//   clk, reset           - clock; synchronous active-low reset
//   prog_valid/ready     - program write handshake (accepted only in IDLE)
//   prog_addr/prog_data  - word address and instruction to store
//   start                - level: IDLE->RUN, HALT->IDLE
//   limit                - retire limit, 0 = unlimited
//   pc, done             - core PC and instruction-complete pulse
//   command              - instruction presented to the core
//   cpu_reset            - active-high core reset, held while in IDLE
//   run, halted, fault   - state flags (fault is sticky until next start)
//   retired              - instructions retired since start
module instr_feeder
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_valid,
    output logic          prog_ready,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_data,
    input  logic          start,
    input  logic [31:0]   limit,
    input  logic [31:0]   pc,
    input  logic          done,
    output logic [31:0]   command,
    output logic          cpu_reset,
    output logic          run,
    output logic          halted,
    output logic          fault,
    output logic [31:0]   retired
);

    feeder_state_t state_q, state_d;
    logic          fetch_q, fetch_d;
    logic          fault_q, fault_d;
    logic [31:0]   retired_q, retired_d;

    logic [AW-1:0] word;
    logic [31:0]   rdata;
    logic          pc_bad;
    logic          is_ebreak;
    logic [31:0]   retired_inc;

    assign word        = pc[AW+1:2];
    // Misaligned, or any address bit above the store set.
    assign pc_bad      = (pc[1:0] != 2'b00) || (pc[31:AW+2] != '0);
    assign is_ebreak   = (rdata == EBREAK);
    assign retired_inc = retired_q + 32'd1;

    prog_mem #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_prog_mem (
        .clk  (clk),
        .we   (prog_valid && (state_q == IDLE)),
        .waddr(prog_addr),
        .wdata(prog_data),
        .raddr(word),
        .rdata(rdata)
    );

    always_comb begin
        state_d   = state_q;
        fetch_d   = 1'b0;
        fault_d   = fault_q;
        retired_d = retired_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    retired_d = 32'd0;
                    fault_d   = 1'b0;
                    fetch_d   = 1'b1;
                end
            end
            RUN: begin
                fetch_d = done;
                if (done) begin
                    retired_d = retired_inc;
                    if ((limit != 32'd0) && (retired_inc == limit)) begin
                        state_d = HALT;
                    end
                end
                // Fetch-cycle checks come last so they win over a coincident done.
                if (fetch_q) begin
                    if (pc_bad) begin
                        state_d = HALT;
                        fault_d = 1'b1;
                    end else if (is_ebreak) begin
                        state_d = HALT;
                    end
                end
            end
            HALT: begin
                if (start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            fetch_q   <= 1'b0;
            fault_q   <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            fetch_q   <= fetch_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
        end
    end

    // EBREAK is never handed to the core; it sees NOP on the halting fetch.
    assign command    = ((state_q == RUN) && !pc_bad && !is_ebreak) ? rdata : NOP;
    assign cpu_reset  = (state_q == IDLE);
    assign run        = (state_q == RUN);
    assign halted     = (state_q == HALT);
    assign prog_ready = (state_q == IDLE);
    assign fault      = fault_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_instr_feeder.sv
// Bench for instr_feeder: a small multicycle core model drives pc/done,
// plus a table of PC -> command vectors applied during RUN.
module tb_instr_feeder;
    import riscv_pkg::*;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          prog_valid = 1'b0;
    logic          prog_ready;
    logic [AW-1:0] prog_addr = '0;
    logic [31:0]   prog_data = '0;
    logic          start = 1'b0;
    logic [31:0]   limit = '0;
    logic [31:0]   pc = '0;
    logic          done = 1'b0;
    logic [31:0]   command;
    logic          cpu_reset, run, halted, fault;
    logic [31:0]   retired;

    always #5 clk = ~clk;

    instr_feeder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .prog_valid(prog_valid),
        .prog_ready(prog_ready),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .limit     (limit),
        .pc        (pc),
        .done      (done),
        .command   (command),
        .cpu_reset (cpu_reset),
        .run       (run),
        .halted    (halted),
        .fault     (fault),
        .retired   (retired)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] regs [32];
    logic [31:0] core_pc;
    logic [31:0] last_ir;
    logic [31:0] first_ir;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cmd;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
        prog_valid = 1'b1;
        prog_addr  = a;
        prog_data  = d;
        tick();
        prog_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic begin_run();
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        core_pc  = 32'd0;
        pc       = 32'd0;
        first_ir = 32'hxxxx_xxxx;
        pulse_start();
    endtask

    task automatic execute(input logic [31:0] ir, input logic [31:0] cur, output logic [31:0] nxt);
        logic [31:0] imm;
        nxt = cur + 32'd4;
        case (ir[6:0])
            OPC_OP_IMM: begin
                if (ir[14:12] == 3'b000)
                    regs[ir[11:7]] = regs[ir[19:15]] + {{20{ir[31]}}, ir[31:20]};
            end
            OPC_JAL: begin
                imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
                regs[ir[11:7]] = cur + 32'd4;
                nxt = cur + imm;
            end
            default: ;
        endcase
        regs[0] = 32'd0;
    endtask

    // Core model: fetch, decode, execute+done; PC updates on the done edge.
    task automatic run_core(input int max_instr);
        logic [31:0] nxt;
        for (int n = 0; n < max_instr && !halted; n++) begin
            pc = core_pc;
            #1;
            last_ir = command;
            if (n == 0) first_ir = command;
            tick();
            if (halted) break;
            tick();
            done = 1'b1;
            execute(last_ir, core_pc, nxt);
            tick();
            done = 1'b0;
            core_pc = nxt;
            pc = core_pc;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h0050_0093};
        vecs[1] = '{32'h0000_0004, 32'h0030_8113};
        vecs[2] = '{32'h0000_0008, NOP};           // EBREAK masked
        vecs[3] = '{32'h0000_00FC, 32'h1234_5678}; // top word
        vecs[4] = '{32'h0000_0002, NOP};           // misaligned
        vecs[5] = '{32'h0000_0100, NOP};           // just past the store
        vecs[6] = '{32'h8000_0000, NOP};           // high bit set
        vecs[7] = '{32'h0000_0005, NOP};

        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;

        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_run", {31'd0, run}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_prog_ready", {31'd0, prog_ready}, 32'd1);
        chk("rst_command", command, NOP);

        // Program: addi x1,x0,5 ; addi x2,x1,3 ; ebreak, plus a marker at the top word.
        load(6'd0, 32'h0050_0093);
        load(6'd1, 32'h0030_8113);
        load(6'd2, EBREAK);
        load(6'd63, 32'h1234_5678);

        begin_run();
        chk("run_flag", {31'd0, run}, 32'd1);
        chk("run_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        chk("run_prog_ready", {31'd0, prog_ready}, 32'd0);
        tick(); // pass the first fetch edge with pc=0

        // Write attempt during RUN must be refused.
        prog_valid = 1'b1;
        prog_addr  = 6'd0;
        prog_data  = 32'hDEAD_BEEF;
        #1;
        chk("blocked_ready", {31'd0, prog_ready}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            pc = vecs[i].pc;
            #1;
            chk($sformatf("vec%0d_command", i), command, vecs[i].cmd);
            tick();
        end
        prog_valid = 1'b0;
        chk("vec_no_halt", {31'd0, halted}, 32'd0);

        // One retire, then reset in the middle of the run.
        pc   = 32'd0;
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("mid_retired_pre", retired, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mid_run", {31'd0, run}, 32'd0);
        chk("mid_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("mid_retired", retired, 32'd0);
        chk("mid_halted", {31'd0, halted}, 32'd0);

        // Basic run (also shows mem[0] survived the blocked write and the reset).
        begin_run();
        run_core(20);
        chk("basic_first_ir", first_ir, 32'h0050_0093);
        chk("basic_x1", regs[1], 32'd5);
        chk("basic_x2", regs[2], 32'd8);
        chk("basic_retired", retired, 32'd2);
        chk("basic_halted", {31'd0, halted}, 32'd1);
        chk("basic_fault", {31'd0, fault}, 32'd0);
        chk("basic_ebreak_nop", last_ir, NOP);
        chk("basic_halt_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        chk("basic_halt_command", command, NOP);

        // HALT -> IDLE reasserts core reset.
        pulse_start();
        chk("h2i_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("h2i_halted", {31'd0, halted}, 32'd0);

        // Retire limit of one.
        limit = 32'd1;
        begin_run();
        run_core(20);
        chk("limit_retired", retired, 32'd1);
        chk("limit_halted", {31'd0, halted}, 32'd1);
        chk("limit_x1", regs[1], 32'd5);
        chk("limit_x2", regs[2], 32'd0);
        limit = 32'd0;

        // Bad PC: jal x0,0x100 leaves the 64-word store.
        pulse_start();
        load(6'd0, 32'h1000_006F);
        begin_run();
        run_core(20);
        chk("badpc_fault", {31'd0, fault}, 32'd1);
        chk("badpc_halted", {31'd0, halted}, 32'd1);
        chk("badpc_retired", retired, 32'd1);
        chk("badpc_nop", last_ir, NOP);
        chk("badpc_pc", core_pc, 32'h0000_0100);

        // Back-to-back writes: jal x0,0xFC at word 0 and EBREAK at the top word.
        pulse_start();
        chk("idle_fault_sticky", {31'd0, fault}, 32'd1);
        load(6'd0, 32'h0FC0_006F);
        load(6'd63, EBREAK);
        begin_run();
        run_core(20);
        chk("b2b_first_ir", first_ir, 32'h0FC0_006F);
        chk("b2b_halted", {31'd0, halted}, 32'd1);
        chk("b2b_fault", {31'd0, fault}, 32'd0);
        chk("b2b_retired", retired, 32'd1);
        chk("b2b_pc", core_pc, 32'h0000_00FC);
        chk("b2b_nop", last_ir, NOP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_feeder.md
# instr_feeder

Instruction-supply front end for the memoryless multicycle RISC-V core (`processor_no_mem`). It holds a small program store that is loaded through a valid/ready write port. It presents `command` at the core's current PC on every fetch cycle and counts retired instructions from the core's `done` pulses. It stops execution on EBREAK, on a retire limit, or on an out-of-range or misaligned PC. It owns the core's (active-high) reset during loading.

## Interface
- `DEPTH`, 64: program store size in 32-bit words (power of two).
- `AW`, $clog2(DEPTH): word-address width (derived, not overridden).
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-low (0 resets).
- `prog_valid` in 1: program write request.
- `prog_ready` out 1: write accepted when valid&ready.
- `prog_addr` in AW: word address.
- `prog_data` in 32: instruction word.
- `start` in 1: level-sampled. IDLE→RUN, or HALT→IDLE.
- `limit` in 32: retire limit, sampled every cycle. 0 = unlimited.
- `pc` in 32: core PC (core's bus slot 38).
- `done` in 1: core instruction-complete.
- `command` out 32: instruction to core.
- `cpu_reset` out 1: active-high reset to core.
- `run` out 1: 1 only in RUN.
- `halted` out 1: 1 in HALT.
- `fault` out 1: sticky, set with HALT on a bad PC.
- `retired` out 32: instructions retired since start.

## Operation
- States are IDLE, RUN and HALT.
- **Reset values:** state=IDLE, cpu_reset=1, run=0, halted=0, fault=0, retired=0, prog_ready=1, command=NOP (0x00000013). Program store is not cleared.
- **IDLE:**
  - prog_ready=1. A write takes effect on the edge where valid&ready.
  - On start=1, go to RUN: retired←0, fault←0, fetch←1.
- **RUN:**
  - cpu_reset=0, run=1, prog_ready=0.
  - `fetch` is a registered flag. It is 1 in the first RUN cycle and in the cycle after every `done`; otherwise 0.
  - word = pc[AW+1:2]. The PC is bad if pc[1:0]≠0 or pc[31:AW+2]≠0.
  - `command`:
    - NOP if the PC is bad.
    - NOP if mem[word]==EBREAK (0x00100073).
    - Otherwise mem[word], driven combinationally.
  - On a fetch cycle with a bad PC: go to HALT, fault←1.
  - On a fetch cycle where mem[word] is EBREAK: go to HALT, fault unchanged.
  - On done=1: retired←retired+1, wrapping at 2^32. If limit≠0 and retired+1==limit, go to HALT.
  - done and fetch never coincide. If they do anyway, the fetch check wins and retired still increments.
- **HALT:**
  - halted=1, command=NOP, cpu_reset=0 so core registers stay inspectable. retired is frozen.
  - start=1 goes to IDLE, which reasserts cpu_reset.
- **Mid-operation reset** (reset=0 in any state): IDLE on the next edge, with all reset values. Memory is retained.
- start is ignored in RUN.

## Timing
- Program write: 1 cycle per word. Back-to-back writes are accepted every cycle in IDLE.
- IDLE→RUN: 1 edge. The first RUN cycle is the core's fetch of PC 0.
- Command path is zero latency (async read), as required because the core latches IR in the fetch cycle itself.
- Halt on EBREAK or bad PC: the core latches NOP on the same edge that takes the feeder to HALT.
- Halt on limit: HALT on the edge of the final done. The core's following fetch sees NOP.
- After halt the core keeps executing NOPs. PC advances; architectural registers are unaffected except the x0 rewrite of 0.

## Structure
- Shared `riscv_pkg` holds:
  - NOP, EBREAK and opcode constants (shared with the core's opcode parameters).
  - The `feeder_state_t` enum {IDLE, RUN, HALT}.
- Sub-module `prog_mem`: DEPTH×32 register array with one synchronous write port and one asynchronous read port, no reset.
- The top level holds the FSM, the fetch flag, the retire counter and the PC checks.

## Test plan
- **Basic run.** Load 0x00500093, 0x00308113, 0x00100073 and start with limit=0 → core x1=5, x2=8; retired=2, halted=1, fault=0.
- **Retire limit.** Same program with limit=1 → halted=1 with retired=1 and x2=0.
- **Bad PC.** DEPTH=64, load jal x0,0x100 (0x1000006F) → fault=1, halted=1, retired=1, and command=NOP on the faulting fetch.
- **Write blocked.** prog_valid=1 at addr 0 during RUN → prog_ready=0 and mem[0] unchanged after returning to IDLE.
- **Mid-run reset.** reset=0 for one cycle during RUN → next cycle IDLE, cpu_reset=1, retired=0. Restart reproduces the basic-run result.
- **Back-to-back writes.** Writes on consecutive cycles to addr 0 and addr DEPTH-1 (an EBREAK at the top word) → both stored. Program jumps there → halt with fault=0.
